pattern_decoder: RTL and testbench
==================================

PATTERN_DECODER -- requirements
Module: pattern_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset==0 clears all state immediately).
REQ-003 SHALL have port code, input, 8 bits: received pattern symbol, sampled only when code_valid==1.
REQ-004 SHALL have port code_valid, input, 1 bit: qualifies code; code_valid==0 cycles are ignored (no state advance).
REQ-005 SHALL have port locked, output, 1 bit: 1 while the FSM is in SYNC.
REQ-006 SHALL have port idx, output, 4 bits: phase index of the most recently accepted sample while locked; 0 in HUNT.
REQ-007 SHALL have port err, output, 1 bit: one-cycle pulse for a mismatched sample while locked.
REQ-008 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a matching sample at phase 15 is accepted.
REQ-009 SHALL have port err_cnt, output, 8 bits: saturating total mismatch count.

Function
REQ-010 SHALL decode a 16-phase pattern: phases 0,2,4,6,8,10,12 = 8'h01; 1=8'h02, 3=8'h04, 5=8'h08, 7=8'h10, 9=8'h20, 11=8'h40, 13=8'h80; 14,15 = 8'h00.
REQ-011 SHALL implement FSM states HUNT (reset state) and SYNC.
REQ-012 HUNT: SHALL track the previous valid sample; two consecutive valid samples equal to 8'h00 -> SYNC, with expected phase set to 0 for the next valid sample.
REQ-013 HUNT: a valid sample that is not 8'h00 SHALL clear the zero history; gaps in code_valid SHALL NOT clear it.
REQ-014 SYNC: each valid sample SHALL be compared with the expected code for the expected phase; the expected phase SHALL then advance modulo 16, whether or not the sample matched.
REQ-015 SYNC: a mismatch SHALL pulse err and increment err_cnt and the consecutive-miss counter; a match SHALL clear the consecutive-miss counter.
REQ-016 SYNC: a third consecutive mismatch SHALL return the FSM to HUNT with the zero history cleared; locked falls in the same registered update.
REQ-017 All outputs SHALL be registered, with 1-cycle latency from the accepting clock edge; idx, err and frame_done SHALL reflect the sample accepted at the previous edge.
REQ-018 The registered update that enters SYNC SHALL set locked=1 and idx=15 (the second zero is phase 15); frame_done SHALL NOT pulse on that update.
REQ-019 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-020 err and frame_done SHALL be 0 in any cycle after code_valid==0.

Reset
REQ-021 reset==0 SHALL asynchronously force HUNT and clear expected phase, miss counter, zero history, locked, idx, err, frame_done and err_cnt to 0.
REQ-022 A reset asserted mid-frame SHALL discard lock; reacquisition SHALL require a fresh 00/00 pair after reset deasserts.

Configuration
REQ-023 Macro PATTERN_DECODER_ERRCNT_EN defined: SHALL implement err_cnt per REQ-015 and REQ-019.
REQ-024 Macro undefined: err_cnt SHALL be constant 0 and no counter register SHALL exist; err and the loss-of-lock logic are unchanged.

Structure
REQ-025 Package pattern_decoder_pkg SHALL hold PERIOD=16, LOSS_LIMIT=3, the HUNT/SYNC state typedef, and the phase-to-code expected function.
REQ-026 Sub-module pattern_expect SHALL be a combinational 4-bit phase -> 8-bit expected-code lookup, instantiated once.

Verification
REQ-027 After reset, drive an ideal stream of 48 valid samples starting at phase 0 -> locked rises one cycle after the first phase-15 sample; frame_done pulses once per 16 samples thereafter; err stays 0; err_cnt=0.
REQ-028 While locked, replace the phase-5 sample with 8'h10 -> a single err pulse, err_cnt=1, locked stays 1, idx continues 6, 7, ...
REQ-029 While locked, drive 3 consecutive wrong samples -> 3 err pulses, err_cnt=3, locked=0 after the third; the next 00/00 pair relocks.
REQ-030 Insert code_valid=0 gaps of 1-5 cycles into the ideal stream -> idx holds during gaps, no err, frame_done timing follows valid samples only.
REQ-031 Assert reset mid-frame (not aligned to clk) -> locked, idx and err_cnt read 0 immediately; relock occurs only after the next 00/00 pair.
REQ-032 With the macro defined, inject 300 mismatches -> err_cnt holds at 8'hFF; with the macro undefined -> err_cnt=0 throughout.

Source files
------------

// File: rtl/pattern_decoder_pkg.sv
// Shared types, sizes and the phase-to-code table for the pattern decoder.
package pattern_decoder_pkg;

  localparam int unsigned PERIOD     = 16;
  localparam int unsigned LOSS_LIMIT = 3;
  localparam int unsigned PHASE_W    = 4;
  localparam int unsigned CODE_W     = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MISS_W     = 2;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  // Even phases below 14 carry 01, odd phases a walking one, 14/15 are the zero sync pair.
  function automatic logic [CODE_W-1:0] expected_code(input logic [PHASE_W-1:0] phase);
    logic [CODE_W-1:0] c;
    c = '0;
    if (phase < PHASE_W'(PERIOD - 2)) begin
      if (phase[0]) c = CODE_W'(1) << (3'(phase[3:1]) + 3'd1);
      else          c = CODE_W'(1);
    end
    return c;
  endfunction

endpackage

// File: rtl/pattern_decoder_expect.sv
// Combinational phase -> expected-code lookup.
module pattern_expect
  import pattern_decoder_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  output logic [CODE_W-1:0]  expected_c
);

  assign expected_c = expected_code(phase);

endmodule

// File: rtl/pattern_decoder.sv
// 16-phase pattern decoder: hunts for a 00/00 pair, then tracks phase and flags mismatches.
// Optional saturating error counter enabled by PATTERN_DECODER_ERRCNT_EN.
module pattern_decoder
  import pattern_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              locked,
  output logic [PHASE_W-1:0] idx,
  output logic              err,
  output logic              frame_done,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                zero_q, zero_d;
  logic                locked_d;
  logic [PHASE_W-1:0]  idx_d;
  logic                err_d;
  logic                frame_done_d;
  logic [CODE_W-1:0]   expected_c;

  pattern_expect u_expect (
    .phase      (phase_q),
    .expected_c (expected_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      phase_q    <= '0;
      miss_q     <= '0;
      zero_q     <= 1'b0;
      locked     <= 1'b0;
      idx        <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      miss_q     <= miss_d;
      zero_q     <= zero_d;
      locked     <= locked_d;
      idx        <= idx_d;
      err        <= err_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state and registered-output values; invalid cycles only clear the pulses.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    miss_d       = miss_q;
    zero_d       = zero_q;
    locked_d     = locked;
    idx_d        = idx;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
    if (code_valid) begin
      case (state_q)
        HUNT: begin
          if (code == '0) begin
            if (zero_q) begin
              state_d  = SYNC;
              phase_d  = '0;
              miss_d   = '0;
              zero_d   = 1'b0;
              locked_d = 1'b1;
              idx_d    = PHASE_W'(PERIOD - 1);
            end else begin
              zero_d = 1'b1;
            end
          end else begin
            zero_d = 1'b0;
          end
        end
        SYNC: begin
          phase_d = phase_q + PHASE_W'(1);
          idx_d   = phase_q;
          if (code == expected_c) begin
            miss_d       = '0;
            frame_done_d = (phase_q == PHASE_W'(PERIOD - 1));
          end else begin
            err_d = 1'b1;
            if (miss_q == MISS_W'(LOSS_LIMIT - 1)) begin
              state_d  = HUNT;
              phase_d  = '0;
              miss_d   = '0;
              zero_d   = 1'b0;
              locked_d = 1'b0;
              idx_d    = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef PATTERN_DECODER_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // err_d is exactly a mismatch accepted in SYNC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_decoder.sv
// Scoreboard bench for pattern_decoder against a table-driven reference model.
module tb_pattern_decoder;

  typedef struct packed {
    logic       locked;
    logic [3:0] idx;
    logic       err;
    logic       fd;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] code;
  logic       code_valid;
  logic       locked;
  logic [3:0] idx;
  logic       err;
  logic       frame_done;
  logic [7:0] err_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  logic [7:0] pat [16] = '{8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h08, 8'h01, 8'h10,
                           8'h01, 8'h20, 8'h01, 8'h40, 8'h01, 8'h80, 8'h00, 8'h00};
  int sp = 0;

  // Reference model state
  bit m_locked, m_zero_prev, m_err, m_fd;
  int m_phase, m_miss, m_cnt, m_idx;

  pattern_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .locked     (locked),
    .idx        (idx),
    .err        (err),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_zero_prev = 0; m_err = 0; m_fd = 0;
    m_phase = 0; m_miss = 0; m_cnt = 0; m_idx = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c);
    m_err = 0;
    m_fd  = 0;
    if (!v) return;
    if (!m_locked) begin
      m_idx = 0;
      if (c == 8'h00 && m_zero_prev) begin
        m_locked = 1; m_phase = 0; m_miss = 0; m_zero_prev = 0; m_idx = 15;
      end else begin
        m_zero_prev = (c == 8'h00);
      end
    end else begin
      m_idx = m_phase;
      if (c == pat[m_phase]) begin
        m_miss = 0;
        m_fd = (m_phase == 15);
      end else begin
        m_err = 1;
        m_miss++;
`ifdef PATTERN_DECODER_ERRCNT_EN
        if (m_cnt < 255) m_cnt++;
`endif
        if (m_miss == 3) begin
          m_locked = 0; m_zero_prev = 0; m_miss = 0; m_idx = 0;
        end
      end
      m_phase = (m_phase + 1) % 16;
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] c);
    exp_t e;
    code_valid = v;
    code       = c;
    @(posedge clk);
    model_step(v, c);
    e.locked = m_locked;
    e.idx    = 4'(m_idx);
    e.err    = m_err;
    e.fd     = m_fd;
    e.cnt    = 8'(m_cnt);
    sb.push_back(e);
    #1;
  endtask

  task automatic ideal();
    drive(1'b1, pat[sp]);
    sp = (sp + 1) % 16;
  endtask

  // Monitor: outputs are registered, so one expectation is due per accepting edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("locked",     32'(locked),     32'(e.locked));
      chk("idx",        32'(idx),        32'(e.idx));
      chk("err",        32'(err),        32'(e.err));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("err_cnt",    32'(err_cnt),    32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    code = '0;
    code_valid = 1'b0;
    model_reset();
    #23;
    chk("rst_locked",  32'(locked),     32'd0);
    chk("rst_idx",     32'(idx),        32'd0);
    chk("rst_err",     32'(err),        32'd0);
    chk("rst_fd",      32'(frame_done), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt),    32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ideal stream of three frames
    for (int i = 0; i < 48; i++) ideal();

    // Single corrupted phase-5 sample
    for (int i = 0; i < 16; i++) begin
      if (sp == 5) begin
        drive(1'b1, 8'h10);
        sp = (sp + 1) % 16;
      end else begin
        ideal();
      end
    end

    // Ideal stream with random valid gaps
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 5)) drive(1'b0, 8'($urandom));
      ideal();
    end

    // Three consecutive mismatches lose lock, then relock on the stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pat[sp] ^ 8'hFF);
      sp = (sp + 1) % 16;
    end
    for (int i = 0; i < 36; i++) ideal();

    // Asynchronous reset mid-frame, off the clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_locked",  32'(locked),  32'd0);
    chk("async_idx",     32'(idx),     32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    code_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) ideal();

    // Repeated lock / triple-miss cycles to push err_cnt into saturation
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'h00);
      drive(1'b1, 8'h00);
      repeat (3) drive(1'b1, 8'h5A);
    end
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h5A);

    // Randomised mix of ideal, corrupt and idle cycles
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 1)      drive(1'b0, 8'($urandom));
      else if (r < 3) drive(1'b1, 8'($urandom));
      else            ideal();
    end

    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
